hub75_bcm_scan: RTL

HUB75_BCM_SCAN -- requirements
Module: hub75_bcm_scan

---
 rtl/hub75_bcm_scan.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hub75_bcm_scan.sv
// hub75_bcm_scan: HUB75 LED panel scanner with binary-coded modulation.
//
// Each (row, plane) pass shifts one bit plane of a row pair into the panel,
// blanks, latches, then lights the panel for BASE_ON<<plane cycles. Planes
// step 0..BPP-1 per row, rows step 0..ROWS-1 per frame.
//
// Ports:
//   i_clk         rising-edge clock
//   i_rst         asynchronous active-high reset
//   i_enable      run scanning while high; sampled at the end of each plane
//   o_rd_addr     frame-buffer read address {row, col}
//   i_rd_data     pixel pair, one cycle after o_rd_addr:
//                 LSB-first {b_lo, g_lo, r_lo, b_up, g_up, r_up}, BPP bits each
//   o_data_r/g/b  shift data, bit0 upper half, bit1 lower half
//   o_clk_enable  panel shift-clock enable, one cycle per column
//   o_latch       panel latch strobe
//   o_blank       panel output-enable, active-high blank
//   o_row         panel row address
//   o_frame_done  one-cycle pulse in the last lit cycle of a frame
module hub75_bcm_scan #(
   parameter int unsigned COLS    = 64,
   parameter int unsigned ROWS    = 16,
   parameter int unsigned BPP     = 4,
   parameter int unsigned BASE_ON = 8
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic                                  i_enable,
   output logic [$clog2(ROWS)+$clog2(COLS)-1:0] o_rd_addr,
   input  logic [6*BPP-1:0]                      i_rd_data,
   output logic [1:0]                            o_data_r,
   output logic [1:0]                            o_data_g,
   output logic [1:0]                            o_data_b,
   output logic                                  o_clk_enable,
   output logic                                  o_latch,
   output logic                                  o_blank,
   output logic [$clog2(ROWS)-1:0]               o_row,
   output logic                                  o_frame_done
);

   localparam int unsigned CW  = $clog2(COLS);
   localparam int unsigned CW1 = CW + 1;
   localparam int unsigned RW  = $clog2(ROWS);
   localparam int unsigned PW  = (BPP > 1) ? $clog2(BPP) : 1;
   localparam int unsigned OW  = $clog2((BASE_ON << (BPP - 1)) + 1);

   typedef enum logic [2:0] {
      StIdle,
      StShift,
      StBlank,
      StLatch,
      StDisplay
   } state_e;

   state_e         state_q;
   // One bit wider than a column index: SHIFT runs COLS+1 cycles so the
   // last read returns before the guard cycle.
   logic [CW:0]    col_q;
   logic [RW-1:0]  row_q;
   logic [PW-1:0]  plane_q;
   logic [OW-1:0]  on_cnt_q;

   logic [OW-1:0]  on_last;
   logic           last_plane;
   logic           frame_end;
   logic [6*BPP-1:0] plane_sh;

   assign on_last    = (OW'(BASE_ON) << plane_q) - OW'(1);
   assign last_plane = (plane_q == PW'(BPP - 1));
   assign frame_end  = last_plane && (row_q == RW'(ROWS - 1));
   assign o_rd_addr  = {row_q, col_q[CW-1:0]};
   // Bring the current plane bit of every field down to the field LSB.
   assign plane_sh   = i_rd_data >> plane_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= StIdle;
         col_q        <= '0;
         row_q        <= '0;
         plane_q      <= '0;
         on_cnt_q     <= '0;
         o_data_r     <= '0;
         o_data_g     <= '0;
         o_data_b     <= '0;
         o_clk_enable <= 1'b0;
         o_latch      <= 1'b0;
         o_blank      <= 1'b1;
         o_row        <= '0;
         o_frame_done <= 1'b0;
      end else begin
         o_clk_enable <= 1'b0;
         o_latch      <= 1'b0;
         o_frame_done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (i_enable) begin
                  state_q <= StShift;
                  row_q   <= '0;
                  plane_q <= '0;
                  col_q   <= '0;
               end
            end
            StShift: begin
               // Read data lags the address by one cycle; data and its
               // shift-clock enable leave together on the same edge.
               if (col_q != '0) begin
                  o_data_r     <= {plane_sh[3*BPP], plane_sh[0]};
                  o_data_g     <= {plane_sh[4*BPP], plane_sh[BPP]};
                  o_data_b     <= {plane_sh[5*BPP], plane_sh[2*BPP]};
                  o_clk_enable <= 1'b1;
               end
               if (col_q == CW1'(COLS)) begin
                  state_q <= StBlank;
               end else begin
                  col_q <= col_q + CW1'(1);
               end
            end
            StBlank: begin
               state_q <= StLatch;
               o_latch <= 1'b1;
               o_row   <= row_q;
            end
            StLatch: begin
               state_q      <= StDisplay;
               o_blank      <= 1'b0;
               on_cnt_q     <= '0;
               o_frame_done <= frame_end && (on_last == '0);
            end
            StDisplay: begin
               if (on_cnt_q == on_last) begin
                  o_blank <= 1'b1;
                  col_q   <= '0;
                  if (last_plane) begin
                     plane_q <= '0;
                     row_q   <= row_q + RW'(1);
                  end else begin
                     plane_q <= plane_q + PW'(1);
                  end
                  state_q <= i_enable ? StShift : StIdle;
               end else begin
                  on_cnt_q     <= on_cnt_q + OW'(1);
                  o_frame_done <= frame_end && ((on_cnt_q + OW'(1)) == on_last);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
